// File: rtl/stepdown_loop_sequencer.sv
// rtl/stepdown_loop_sequencer.sv - constant-on-time loop sequencer for the step-down converter
//
// Generates the high-side phase strobe (Tstate) and low-side enable (lo_on) with
// soft-start, dead time, min-off time, cycle-by-cycle current limit and OCP fault latch.
//
// Ports:
//   clk      in   loop clock
//   rst      in   asynchronous reset, active high
//   en       in   converter enable
//   fb_low   in   feedback comparator, 1 = output below target
//   ilim     in   cycle-by-cycle current limit comparator
//   ton_cfg  in   target on-time in cycles (floored at TON_MIN)
//   Tstate   out  high-side on
//   lo_on    out  low-side on
//   ss_done  out  soft-start complete
//   fault    out  over-current fault latched
//   state_o  out  encoded FSM state
module stepdown_loop_sequencer #(
  parameter int CNT_W    = 8,
  parameter int TON_MIN  = 4,
  parameter int TOFF_MIN = 4,
  parameter int DEAD     = 2,
  parameter int BLANK    = 2,
  parameter int OCP_N    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fb_low,
  input  logic             ilim,
  input  logic [CNT_W-1:0] ton_cfg,
  output logic             Tstate,
  output logic             lo_on,
  output logic             ss_done,
  output logic             fault,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ON    = 3'd1,
    DT1   = 3'd2,
    OFF   = 3'd3,
    DT2   = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam int OCP_W = $clog2(OCP_N + 1);
  localparam logic [CNT_W-1:0] TON_MIN_C = CNT_W'(TON_MIN);
  localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD - 1);
  localparam logic [CNT_W-1:0] TOFF_END  = CNT_W'(TOFF_MIN - 1);
  localparam logic [CNT_W-1:0] BLANK_C   = CNT_W'(BLANK);
  localparam logic [OCP_W-1:0] OCP_C     = OCP_W'(OCP_N);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   ss_ton, ss_ton_n;
  logic [CNT_W-1:0]   ton_eff, ton_eff_n;
  logic [OCP_W-1:0]   ocp_cnt, ocp_n;
  logic               ss_done_n;
  logic               on_exit;
  logic [CNT_W-1:0]   ton_pick, ton_calc;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ss_ton_n  = ss_ton;
    ton_eff_n = ton_eff;
    ocp_n     = ocp_cnt;
    ss_done_n = ss_done;
    on_exit   = 1'b0;
    ton_pick  = (ton_cfg < ss_ton) ? ton_cfg : ss_ton;
    ton_calc  = (ton_pick < TON_MIN_C) ? TON_MIN_C : ton_pick;

    case (state)
      IDLE: begin
        if (en && fb_low) begin
          state_n  = DT2;
          cnt_n    = '0;
          ss_ton_n = TON_MIN_C;
        end
      end
      DT2: begin
        if (cnt == DEAD_END) begin
          state_n   = ON;
          cnt_n     = '0;
          ton_eff_n = ton_calc;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ON: begin
        // A limit hit past blanking wins over a coincident normal end so it is
        // still counted toward the fault latch.
        if (ilim && (cnt >= BLANK_C)) begin
          state_n = DT1;
          cnt_n   = '0;
          ocp_n   = ocp_cnt + 1'b1;
          on_exit = 1'b1;
        end else if (cnt == ton_eff - 1'b1) begin
          state_n = DT1;
          cnt_n   = '0;
          ocp_n   = '0;
          on_exit = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DT1: begin
        if (cnt == DEAD_END) begin
          state_n = (ocp_cnt == OCP_C) ? FAULT : OFF;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      OFF: begin
        // cnt saturates at the end of the min-off window so a long wait never wraps.
        if ((cnt >= TOFF_END) && fb_low) begin
          state_n = DT2;
          cnt_n   = '0;
        end else if (cnt < TOFF_END) begin
          cnt_n = cnt + 1'b1;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // ss_done looks at the on-time just finished, so it rises after the first
    // full-length pulse rather than after the ramp step that reaches ton_cfg.
    if (on_exit) begin
      if (ss_ton >= ton_cfg) ss_done_n = 1'b1;
      if (ss_ton < ton_cfg)  ss_ton_n  = ss_ton + 1'b1;
    end

    if (!en) state_n = IDLE;

    if (state_n == IDLE) begin
      cnt_n     = '0;
      ss_ton_n  = '0;
      ton_eff_n = '0;
      ocp_n     = '0;
      ss_done_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ss_ton  <= '0;
      ton_eff <= '0;
      ocp_cnt <= '0;
      ss_done <= 1'b0;
      Tstate  <= 1'b0;
      lo_on   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ss_ton  <= ss_ton_n;
      ton_eff <= ton_eff_n;
      ocp_cnt <= ocp_n;
      ss_done <= ss_done_n;
      Tstate  <= (state_n == ON);
      lo_on   <= (state_n == OFF);
      fault   <= (state_n == FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_stepdown_loop_sequencer.sv
// tb/tb_stepdown_loop_sequencer.sv - directed self-checking bench for stepdown_loop_sequencer
module tb_stepdown_loop_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       fb_low;
  logic       ilim;
  logic [7:0] ton_cfg;
  logic       Tstate;
  logic       lo_on;
  logic       ss_done;
  logic       fault;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  stepdown_loop_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .fb_low  (fb_low),
    .ilim    (ilim),
    .ton_cfg (ton_cfg),
    .Tstate  (Tstate),
    .lo_on   (lo_on),
    .ss_done (ss_done),
    .fault   (fault),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; fb_low = 1'b0; ilim = 1'b0; ton_cfg = 8'd8;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_rise(output bit ok);
    for (int c = 0; c < 100 && !Tstate; c++) step();
    ok = Tstate;
  endtask

  // ilim_at >= 0: pulse ilim for the ON cycle with that count; -1: never; -2: hold high.
  task automatic run_pulse(input int ilim_at, output int width);
    bit ok;
    int k;
    wait_rise(ok);
    width = -1;
    if (ok) begin
      width = 0;
      k = 0;
      while (Tstate && k < 300) begin
        width++;
        if (ilim_at == -2) ilim = 1'b1;
        else               ilim = (k == ilim_at);
        step();
        k++;
      end
      if (ilim_at != -2) ilim = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; fb_low = 1'b0; ilim = 1'b0; ton_cfg = 8'd8;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({Tstate, lo_on, ss_done, fault, state_o} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got T=%b lo=%b ss=%b f=%b st=%0d, want all 0",
               Tstate, lo_on, ss_done, fault, state_o);
    end
    rst = 1'b0;
    fb_low = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL idle_without_en: state_o=%0d, want 0", state_o);
    end
  endtask

  task automatic test_soft_start();
    int  exp_w[6] = '{4, 5, 6, 7, 8, 8};
    int  widths[6];
    int  gaps[5];
    int  los[5];
    int  np = 0, run = 0, low_run = 0, lo_run = 0;
    logic prev_t = 1'b0, prev_ss = 1'b0;
    bit  overlap = 0, ss_ok = 0;
    apply_reset();
    ton_cfg = 8'd8; en = 1'b1; fb_low = 1'b1;
    for (int c = 0; c < 400 && np < 6; c++) begin
      step();
      if (Tstate && lo_on) overlap = 1;
      if (Tstate) begin
        if (!prev_t && np > 0) begin
          gaps[np-1] = low_run;
          los[np-1]  = lo_run;
        end
        run++;
      end else begin
        if (prev_t) begin
          widths[np] = run;
          if (np == 4) ss_ok = (ss_done === 1'b1) && (prev_ss === 1'b0);
          np++;
          run = 0; low_run = 0; lo_run = 0;
        end
        low_run++;
        if (lo_on) lo_run++;
      end
      prev_t = Tstate;
      prev_ss = ss_done;
    end
    n_cmp++;
    if (np != 6) begin
      n_bad++;
      $display("FAIL ss_timeout: saw %0d pulses, want 6", np);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (widths[i] != exp_w[i]) begin
          n_bad++;
          $display("FAIL ss_width[%0d]: got %0d, want %0d", i, widths[i], exp_w[i]);
        end
      end
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (gaps[i] != 8 || los[i] != 4) begin
          n_bad++;
          $display("FAIL ss_gap[%0d]: low=%0d lo_on=%0d, want low=8 lo_on=4", i, gaps[i], los[i]);
        end
      end
      n_cmp++;
      if (!ss_ok) begin
        n_bad++;
        $display("FAIL ss_done_rise: not 0->1 right after first 8-cycle pulse, want rise there");
      end
    end
    n_cmp++;
    if (overlap) begin
      n_bad++;
      $display("FAIL overlap: Tstate and lo_on both 1, want never");
    end
  endtask

  task automatic test_min_off_wait();
    int held = 0;
    fb_low = 1'b0;
    for (int c = 0; c < 50 && !lo_on; c++) step();
    for (int i = 0; i < 20; i++) begin
      step();
      if (lo_on === 1'b1) held++;
    end
    n_cmp++;
    if (held != 20) begin
      n_bad++;
      $display("FAIL off_hold: lo_on high %0d of 20 waiting cycles, want 20", held);
    end
    fb_low = 1'b1;
    step();
    n_cmp++;
    if (state_o !== 3'd4 || lo_on !== 1'b0 || ss_done !== 1'b1) begin
      n_bad++;
      $display("FAIL off_to_dt2: st=%0d lo=%b ss=%b, want st=4 lo=0 ss=1", state_o, lo_on, ss_done);
    end
  endtask

  task automatic test_blanking();
    int w;
    run_pulse(1, w);
    n_cmp++;
    if (w != 8) begin
      n_bad++;
      $display("FAIL blank_ignore: width %0d, want 8", w);
    end
    run_pulse(3, w);
    n_cmp++;
    if (w != 4) begin
      n_bad++;
      $display("FAIL ilim_trunc: width %0d, want 4", w);
    end
  endtask

  task automatic test_ocp_fault();
    int w;
    bit quiet = 1;
    run_pulse(-1, w);
    n_cmp++;
    if (w != 8) begin
      n_bad++;
      $display("FAIL ocp_clear_pulse: width %0d, want 8", w);
    end
    for (int i = 0; i < 4; i++) begin
      run_pulse(-2, w);
      n_cmp++;
      if (w != 3) begin
        n_bad++;
        $display("FAIL ocp_pulse[%0d]: width %0d, want 3", i, w);
      end
    end
    step();
    step();
    n_cmp++;
    if (state_o !== 3'd5 || fault !== 1'b1 || Tstate !== 1'b0 || lo_on !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_entry: st=%0d f=%b T=%b lo=%b, want st=5 f=1 T=0 lo=0",
               state_o, fault, Tstate, lo_on);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (Tstate !== 1'b0 || lo_on !== 1'b0 || fault !== 1'b1) quiet = 0;
    end
    n_cmp++;
    if (!quiet) begin
      n_bad++;
      $display("FAIL fault_hold: switching or fault drop while latched, want quiet with fault=1");
    end
    ilim = 1'b0;
    en = 1'b0;
    step();
    n_cmp++;
    if (state_o !== 3'd0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_exit: st=%0d f=%b, want st=0 f=0", state_o, fault);
    end
  endtask

  task automatic test_disable_mid_on();
    int w;
    bit ok;
    ton_cfg = 8'd2; en = 1'b1; fb_low = 1'b1;
    run_pulse(-1, w);
    n_cmp++;
    if (w != 4 || ss_done !== 1'b1) begin
      n_bad++;
      $display("FAIL ton_floor: width %0d ss=%b, want width 4 ss=1", w, ss_done);
    end
    wait_rise(ok);
    step();
    step();
    en = 1'b0;
    step();
    n_cmp++;
    if (!ok || Tstate !== 1'b0 || lo_on !== 1'b0 || state_o !== 3'd0 || ss_done !== 1'b0) begin
      n_bad++;
      $display("FAIL disable_on: rise=%0b T=%b lo=%b st=%0d ss=%b, want T=0 lo=0 st=0 ss=0",
               ok, Tstate, lo_on, state_o, ss_done);
    end
  endtask

  task automatic test_async_reset();
    bit quiet = 1;
    ton_cfg = 8'd8; en = 1'b1; fb_low = 1'b1;
    for (int c = 0; c < 100 && !lo_on; c++) step();
    n_cmp++;
    if (lo_on !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_reach_off: lo_on=%b, want 1", lo_on);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (lo_on !== 1'b0 || Tstate !== 1'b0 || state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL arst_immediate: lo=%b T=%b st=%0d, want 0 0 0", lo_on, Tstate, state_o);
    end
    rst = 1'b0;
    fb_low = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({Tstate, lo_on, ss_done, fault, state_o} !== 7'd0) quiet = 0;
    end
    n_cmp++;
    if (!quiet) begin
      n_bad++;
      $display("FAIL arst_hold: outputs left 0 without fb_low, want all 0");
    end
    fb_low = 1'b1;
    step();
    n_cmp++;
    if (state_o !== 3'd4 || Tstate !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_restart_dt2: st=%0d T=%b, want st=4 T=0", state_o, Tstate);
    end
    step();
    step();
    n_cmp++;
    if (state_o !== 3'd1 || Tstate !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_restart_on: st=%0d T=%b, want st=1 T=1", state_o, Tstate);
    end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_min_off_wait();
    test_blanking();
    test_ocp_fault();
    test_disable_mid_on();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
